// File: rtl/lcd_text_ctrl.sv
// HD44780 16x2 character LCD sequencer: power-up wait, init commands, then
// scans a 32-entry character ROM and writes it with fixed E-strobe timing.
module lcd_text_ctrl #(
    parameter int unsigned T_POWERUP    = 750000,
    parameter int unsigned T_SETUP      = 4,
    parameter int unsigned T_EN         = 12,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh,
    input  logic [6:0] char_code,
    output logic [7:0] char_xy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       ready,
    output logic       frame_done
);
    localparam int unsigned CW = 20;

    typedef enum logic [2:0] {
        S_POWER, S_INIT, S_ADDR0, S_ROW0, S_ADDR1, S_ROW1, S_IDLE
    } state_t;

    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

    state_t        state, state_nxt;
    phase_t        phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    step, step_nxt;
    logic [4:0]    xy, xy_nxt;
    logic [7:0]    data_nxt;
    logic          rs_nxt, e_nxt, ready_nxt, done_nxt;
    logic          pend, pend_nxt;

    logic          last_c, wait_long_c, adv_xy_c;
    logic          start_c, start_rs_c, enter_addr0_c;
    logic [7:0]    start_data_c;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign lcd_rw      = 1'b0;
    assign char_xy     = {3'b000, xy};
    assign wait_long_c = !lcd_rs && (lcd_data == 8'h01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_POWER;
            phase      <= P_SETUP;
            cnt        <= CW'(T_POWERUP - 1);
            step       <= 2'd0;
            xy         <= 5'd0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
            pend       <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            cnt        <= cnt_nxt;
            step       <= step_nxt;
            xy         <= xy_nxt;
            lcd_data   <= data_nxt;
            lcd_rs     <= rs_nxt;
            lcd_e      <= e_nxt;
            ready      <= ready_nxt;
            frame_done <= done_nxt;
            pend       <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        step_nxt      = step;
        xy_nxt        = xy;
        data_nxt      = lcd_data;
        rs_nxt        = lcd_rs;
        e_nxt         = lcd_e;
        ready_nxt     = ready;
        done_nxt      = 1'b0;
        pend_nxt      = pend;
        start_c       = 1'b0;
        start_rs_c    = 1'b0;
        start_data_c  = 8'h00;
        enter_addr0_c = 1'b0;
        last_c        = (cnt == '0);
        cnt_nxt       = last_c ? cnt : cnt - CW'(1);

        // ROM address advances one cycle before the WAIT ends so the next SETUP samples a settled ROM
        adv_xy_c = (phase == P_WAIT && cnt == CW'(1)) ||
                   (T_CMD == 1 && phase == P_PULSE && last_c);

        if (refresh && state != S_POWER && state != S_INIT && state != S_IDLE)
            pend_nxt = 1'b1;

        if ((state == S_ROW0 || state == S_ROW1) && adv_xy_c)
            xy_nxt = xy + 5'd1;

        case (state)
            S_POWER: begin
                if (last_c) begin
                    state_nxt    = S_INIT;
                    step_nxt     = 2'd0;
                    start_c      = 1'b1;
                    start_data_c = init_cmd(2'd0);
                end
            end
            S_IDLE: begin
                if (pend || refresh) begin
                    ready_nxt     = 1'b0;
                    enter_addr0_c = 1'b1;
                end
            end
            default: begin
                case (phase)
                    P_SETUP: begin
                        if (last_c) begin
                            phase_nxt = P_PULSE;
                            cnt_nxt   = CW'(T_EN - 1);
                            e_nxt     = 1'b1;
                        end
                    end
                    P_PULSE: begin
                        if (last_c) begin
                            phase_nxt = P_WAIT;
                            cnt_nxt   = wait_long_c ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
                            e_nxt     = 1'b0;
                        end
                    end
                    default: begin
                        if (last_c) begin
                            case (state)
                                S_INIT: begin
                                    if (step == 2'd3) begin
                                        enter_addr0_c = 1'b1;
                                    end else begin
                                        step_nxt     = step + 2'd1;
                                        start_c      = 1'b1;
                                        start_data_c = init_cmd(step + 2'd1);
                                    end
                                end
                                S_ADDR0: begin
                                    state_nxt    = S_ROW0;
                                    start_c      = 1'b1;
                                    start_rs_c   = 1'b1;
                                    start_data_c = {1'b0, char_code};
                                end
                                S_ROW0: begin
                                    start_c = 1'b1;
                                    if (xy[4]) begin
                                        state_nxt    = S_ADDR1;
                                        start_data_c = 8'hC0;
                                    end else begin
                                        start_rs_c   = 1'b1;
                                        start_data_c = {1'b0, char_code};
                                    end
                                end
                                S_ADDR1: begin
                                    state_nxt    = S_ROW1;
                                    start_c      = 1'b1;
                                    start_rs_c   = 1'b1;
                                    start_data_c = {1'b0, char_code};
                                end
                                default: begin
                                    if (xy == 5'd0) begin
                                        done_nxt = 1'b1;
                                        if (AUTO_REFRESH) begin
                                            enter_addr0_c = 1'b1;
                                        end else begin
                                            state_nxt = S_IDLE;
                                            ready_nxt = 1'b1;
                                        end
                                    end else begin
                                        start_c      = 1'b1;
                                        start_rs_c   = 1'b1;
                                        start_data_c = {1'b0, char_code};
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase

        if (enter_addr0_c) begin
            state_nxt    = S_ADDR0;
            pend_nxt     = 1'b0;
            xy_nxt       = 5'd0;
            start_c      = 1'b1;
            start_rs_c   = 1'b0;
            start_data_c = 8'h80;
        end

        if (start_c) begin
            phase_nxt = P_SETUP;
            cnt_nxt   = CW'(T_SETUP - 1);
            data_nxt  = start_data_c;
            rs_nxt    = start_rs_c;
            e_nxt     = 1'b0;
        end
    end
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl: init/frame pulse table, refresh handling,
// mid-transaction reset and the auto-refresh variant.
module tb_lcd_text_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, refresh;
    logic [6:0] char_code, char_code2;
    logic [7:0] char_xy, lcd_data, char_xy2, lcd_data2;
    logic       lcd_rs, lcd_rw, lcd_e, ready, frame_done;
    logic       lcd_rs2, lcd_rw2, lcd_e2, ready2, frame_done2;
    logic [7:0] rom [32];

    assign char_code  = rom[char_xy[4:0]][6:0];
    assign char_code2 = rom[char_xy2[4:0]][6:0];

    lcd_text_ctrl #(.T_POWERUP(10), .T_SETUP(1), .T_EN(2), .T_CMD(3), .T_CLEAR(5),
                    .AUTO_REFRESH(1'b0)) u_dut (
        .clk(clk), .reset(reset), .refresh(refresh), .char_code(char_code),
        .char_xy(char_xy), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .ready(ready), .frame_done(frame_done));

    lcd_text_ctrl #(.T_POWERUP(10), .T_SETUP(1), .T_EN(2), .T_CMD(3), .T_CLEAR(5),
                    .AUTO_REFRESH(1'b1)) u_auto (
        .clk(clk), .reset(reset), .refresh(1'b0), .char_code(char_code2),
        .char_xy(char_xy2), .lcd_data(lcd_data2), .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2),
        .lcd_e(lcd_e2), .ready(ready2), .frame_done(frame_done2));

    typedef struct { logic [7:0] data; logic rs; logic [7:0] xy; int gap; } vec_t;
    typedef struct { logic [7:0] data; logic rs; logic [7:0] xy; int rise; int fall; } ev_t;

    vec_t vec [38];
    ev_t  ev_q [$];
    int   done_q [$], ready_q [$], done2_q [$];
    int   ready2_high, hold_err, cyc, n_chk, n_fail;
    logic prev_e, prev_rs, prev_ready;
    logic [7:0] prev_data;

    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] frame_exp [34] = '{8'h80,
        8'h20, 8'h20, 8'h20, 8'h44, 8'h49, 8'h46, 8'h46, 8'h49,
        8'h43, 8'h55, 8'h4C, 8'h54, 8'h59, 8'h3A, 8'h20, 8'h20,
        8'hC0,
        8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h48, 8'h41,
        8'h52, 8'h44, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Event recorder: E edges, ready rises, frame_done pulses, data stability
    always @(negedge clk) begin
        ev_t t;
        if (lcd_e && !prev_e) begin
            t.data = lcd_data; t.rs = lcd_rs; t.xy = char_xy; t.rise = cyc; t.fall = -1;
            ev_q.push_back(t);
        end
        if (!lcd_e && prev_e && ev_q.size() > 0) begin
            t = ev_q.pop_back();
            t.fall = cyc;
            ev_q.push_back(t);
        end
        if (!reset && (lcd_e || prev_e) && (lcd_data != prev_data || lcd_rs != prev_rs))
            hold_err++;
        if (frame_done) done_q.push_back(cyc);
        if (ready && !prev_ready) ready_q.push_back(cyc);
        if (frame_done2) done2_q.push_back(cyc);
        if (ready2) ready2_high++;
        prev_e = lcd_e; prev_rs = lcd_rs; prev_data = lcd_data; prev_ready = ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk); #1;
        refresh = 1'b0;
    endtask

    task automatic clear_logs();
        ev_q.delete(); done_q.delete(); ready_q.delete(); done2_q.delete();
        ready2_high = 0; hold_err = 0;
    endtask

    task automatic check_events(input int eb, input int vb, input int n, input int first_gap);
        for (int i = 0; i < n && eb + i < ev_q.size(); i++) begin
            int   k;
            int   g_act;
            int   g_exp;
            ev_t  e;
            vec_t v;
            k = eb + i;
            e = ev_q[k];
            v = vec[vb + i];
            chk($sformatf("data[%0d]", k), e.data, v.data);
            chk($sformatf("rs[%0d]", k), e.rs, v.rs);
            chk($sformatf("xy[%0d]", k), e.xy, v.xy);
            chk($sformatf("e_width[%0d]", k), e.fall - e.rise, 2);
            if (i > 0 || first_gap >= 0) begin
                g_exp = (i == 0) ? first_gap : v.gap;
                g_act = (k == 0) ? e.rise : e.rise - ev_q[k - 1].fall;
                chk($sformatf("gap[%0d]", k), g_act, g_exp);
            end
        end
    endtask

    // Release reset and check power-up, init and the mandatory first frame
    task automatic startup(input bit drop);
        int bad = 0;
        clear_logs();
        reset = 1'b0;
        while (cyc < 10) begin
            refresh = drop && (cyc == 3);
            if (lcd_e || lcd_rs || lcd_data != 8'h00 || char_xy != 8'h00 || ready || frame_done)
                bad++;
            @(negedge clk); #1;
        end
        refresh = 1'b0;
        chk("power_hold", bad, 0);
        if (drop) begin
            wait_cyc(15);
            pulse_refresh();
        end
        wait_cyc(300);
        chk("pulse_count", ev_q.size(), 38);
        check_events(0, 0, 38, 11);
        chk("ready_rises", ready_q.size(), 1);
        if (ready_q.size() > 0) chk("ready_cycle", ready_q[0], 240);
        chk("frame_done_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("frame_done_cycle", done_q[0], 240);
        chk("ready_idle", ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string s0, s1;
        int t0, n;
        n_chk = 0; n_fail = 0;
        prev_e = 1'b0; prev_rs = 1'b0; prev_data = 8'h00; prev_ready = 1'b0;
        reset = 1'b1; refresh = 1'b0;
        s0 = "   DIFFICULTY:  ";
        s1 = "      HARD      ";
        for (int i = 0; i < 16; i++) begin
            rom[i]      = s0[i];
            rom[i + 16] = s1[i];
        end
        for (int i = 0; i < 4; i++)
            vec[i] = '{init_cmds[i], 1'b0, 8'h00, (i == 0) ? 11 : ((i == 3) ? 6 : 4)};
        for (int j = 0; j < 34; j++) begin
            logic [7:0] x;
            if (j == 0)       x = 8'h00;
            else if (j <= 16) x = 8'(j - 1);
            else if (j == 17) x = 8'h10;
            else              x = 8'(8'h10 + (j - 18));
            vec[4 + j] = '{frame_exp[j], (j != 0 && j != 17), x, 4};
        end
        clear_logs();

        repeat (3) @(negedge clk);
        #1;
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_xy", char_xy, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_auto_e", lcd_e2, 1'b0);

        // Power-up, init and first frame
        startup(1'b0);
        wait_cyc(340);
        chk("idle_no_pulses", ev_q.size(), 38);

        // Refresh from IDLE, then three refreshes during the frame collapse into one
        clear_logs();
        t0 = cyc;
        pulse_refresh();
        chk("idle_ready_fall", ready, 1'b0);
        chk("idle_addr0_data", lcd_data, 8'h80);
        chk("idle_addr0_e", lcd_e, 1'b0);
        chk("idle_addr0_rs", lcd_rs, 1'b0);
        @(negedge clk); #1;
        chk("idle_addr0_e_rise", lcd_e, 1'b1);
        wait_cyc(t0 + 20);  pulse_refresh();
        wait_cyc(t0 + 60);  pulse_refresh();
        wait_cyc(t0 + 150); pulse_refresh();
        wait_cyc(t0 + 440);
        chk("two_frame_pulses", ev_q.size(), 68);
        check_events(0, 4, 34, -1);
        check_events(34, 4, 34, 5);
        chk("two_frame_done_count", done_q.size(), 2);
        if (done_q.size() > 1) begin
            chk("frame1_done_cycle", done_q[0], t0 + 205);
            chk("frame2_done_interval", done_q[1] - done_q[0], 205);
        end
        chk("two_frame_ready_rises", ready_q.size(), 2);
        chk("two_frame_ready_end", ready, 1'b1);
        chk("hold_stable", hold_err, 0);

        // Reset during an E pulse in ROW0, then restart with refreshes dropped in POWER/INIT
        pulse_refresh();
        n = 0;
        while (!(lcd_e && lcd_rs && char_xy == 8'h03) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("row0_pulse_reached", (n < 100), 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_e", lcd_e, 1'b0);
        chk("midrst_data", lcd_data, 8'h00);
        chk("midrst_xy", char_xy, 8'h00);
        chk("midrst_rs", lcd_rs, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        startup(1'b1);
        chk("hold_stable_restart", hold_err, 0);

        // Auto-refresh instance ran alongside since the last reset release
        wait_cyc(870);
        chk("auto_done_count", done2_q.size(), 4);
        for (int i = 0; i < 4 && i < done2_q.size(); i++)
            chk($sformatf("auto_done_cycle[%0d]", i), done2_q[i], 240 + 204 * i);
        chk("auto_ready_never", ready2_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
